pc_sequencer: RTL and testbench

- Program-counter and call-stack sequencer for the PIC16C5x core. Sits between the control unit, which issues one flow command per instruction cycle, and program memory, which is addressed by pc.
- Owns the two-level hardware stack. Signals pipeline flush whenever the prefetched instruction must be discarded: jump, call, return, PCL write, or a taken skip.

---
 rtl/pc_sequencer_pkg.sv | 14 +
 rtl/pc_sequencer_stack.sv | 42 ++++
 rtl/pc_sequencer.sv | 66 ++++++
 tb/tb_pc_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: flow-command codes, Q-phase codes and sizing defaults for the PC sequencer
package pc_sequencer_pkg;
  typedef enum logic [2:0] {
    PC_CMD_SEQ   = 3'd0,
    PC_CMD_GOTO  = 3'd1,
    PC_CMD_CALL  = 3'd2,
    PC_CMD_RETLW = 3'd3,
    PC_CMD_PCLW  = 3'd4,
    PC_CMD_SKIP  = 3'd5
  } pc_cmd_e;
  typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} q_phase_e;
  localparam int PC_WIDTH_DEF = 11;
  localparam logic [10:0] RESET_VECTOR_DEF = 11'h7FF;
endpackage

// File: rtl/pc_sequencer_stack.sv
// pc_stack: two-level 16C5x return stack; pop copies lvl1 down and leaves lvl1 in place
module pc_stack #(
  parameter int W = 11,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_top,
  output logic [1:0]   o_depth,
  output logic         o_ovf,
  output logic         o_unf
);
  localparam logic [1:0] MAX = 2'(DEPTH);
  logic [W-1:0] r_lvl0, r_lvl1;
  logic [1:0] r_depth;
  logic r_ovf, r_unf;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lvl0  <= '0;
      r_lvl1  <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (i_push) begin
      r_lvl1  <= r_lvl0;
      r_lvl0  <= i_data;
      r_depth <= r_depth == MAX ? MAX : r_depth + 2'd1;
      r_ovf   <= r_ovf | (r_depth == MAX);
    end else if (i_pop) begin
      r_lvl0  <= r_lvl1;
      r_depth <= r_depth == 2'd0 ? 2'd0 : r_depth - 2'd1;
      r_unf   <= r_unf | (r_depth == 2'd0);
    end
  end
  assign o_top   = r_lvl0;
  assign o_depth = r_depth;
  assign o_ovf   = r_ovf;
  assign o_unf   = r_unf;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PIC16C5x program counter, call stack and prefetch-flush control, updated once per Q4
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF,
  parameter int STACK_DEPTH = 2,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEF[PC_WIDTH-1:0]
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          q_phase,
  input  logic                ex_valid,
  input  logic [2:0]          ex_cmd,
  input  logic [8:0]          lit,
  input  logic [1:0]          pa,
  input  logic [7:0]          pcl_wdata,
  input  logic                halt,
  output logic [PC_WIDTH-1:0] pc,
  output logic                flush,
  output logic [1:0]          stk_depth,
  output logic                stk_ovf,
  output logic                stk_unf
);
  logic w_edge, w_push, w_pop, w_flush_nxt, r_flush;
  logic [2:0] w_cmd;
  logic [10:0] w_goto_full, w_call_full, w_pclw_full;
  logic [PC_WIDTH-1:0] r_pc, w_inc, w_top, w_pc_nxt;
  assign w_edge = q_phase == Q4;
  assign w_cmd  = ex_valid ? ex_cmd : PC_CMD_SEQ;
  assign w_inc  = r_pc + PC_WIDTH'(1);
  // Page bits sit above the 9-bit literal; slicing to PC_WIDTH drops them on narrower cores
  assign w_goto_full = {pa, lit};
  assign w_call_full = {pa, 1'b0, lit[7:0]};
  assign w_pclw_full = {pa, 1'b0, pcl_wdata};
  assign w_push = w_edge && w_cmd == PC_CMD_CALL;
  assign w_pop  = w_edge && w_cmd == PC_CMD_RETLW;
  assign w_flush_nxt = w_cmd != PC_CMD_SEQ && w_cmd <= PC_CMD_SKIP;
  assign w_pc_nxt = w_cmd == PC_CMD_GOTO  ? w_goto_full[PC_WIDTH-1:0] :
                    w_cmd == PC_CMD_CALL  ? w_call_full[PC_WIDTH-1:0] :
                    w_cmd == PC_CMD_RETLW ? w_top :
                    w_cmd == PC_CMD_PCLW  ? w_pclw_full[PC_WIDTH-1:0] :
                    w_cmd == PC_CMD_SKIP  ? w_inc :
                    halt                  ? r_pc : w_inc;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc    <= RESET_VECTOR;
      r_flush <= 1'b1;
    end else if (w_edge) begin
      r_pc    <= w_pc_nxt;
      r_flush <= w_flush_nxt;
    end
  end
  pc_stack #(.W(PC_WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_inc),
    .o_top   (w_top),
    .o_depth (stk_depth),
    .o_ovf   (stk_ovf),
    .o_unf   (stk_unf)
  );
  assign pc    = r_pc;
  assign flush = r_flush;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table plus randomized commands against a queue-based reference model
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, ex_valid = 1'b0, halt = 1'b0;
  logic [1:0] q_phase = 2'd0, pa = 2'd0;
  logic [2:0] ex_cmd = 3'd0;
  logic [8:0] lit = 9'd0;
  logic [7:0] pcl_wdata = 8'd0;
  logic [10:0] pc;
  logic flush, stk_ovf, stk_unf;
  logic [1:0] stk_depth;
  int n_pass = 0, n_total = 0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .q_phase(q_phase), .ex_valid(ex_valid), .ex_cmd(ex_cmd),
    .lit(lit), .pa(pa), .pcl_wdata(pcl_wdata), .halt(halt), .pc(pc), .flush(flush),
    .stk_depth(stk_depth), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    bit v; logic [2:0] c; logic [8:0] l; logic [1:0] p; logic [7:0] w; bit h;
    logic [10:0] e_pc; bit e_fl; logic [1:0] e_d; bit e_o; bit e_u;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit v, logic [2:0] c, logic [8:0] l, logic [1:0] p, logic [7:0] w,
                              bit h, logic [10:0] e_pc, bit e_fl, logic [1:0] e_d, bit e_o, bit e_u);
    vec_t r;
    r.v = v; r.c = c; r.l = l; r.p = p; r.w = w; r.h = h;
    r.e_pc = e_pc; r.e_fl = e_fl; r.e_d = e_d; r.e_o = e_o; r.e_u = e_u;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One instruction cycle: Q1..Q4 with inputs held; optionally checks pc holds between edges
  task automatic icycle(input bit v, input logic [2:0] c, input logic [8:0] l, input logic [1:0] p,
                        input logic [7:0] w, input bit h, input bit stab, input string tag);
    logic [10:0] pc0;
    pc0 = pc;
    for (int q = 0; q < 4; q++) begin
      @(negedge clk);
      q_phase = 2'(q); ex_valid = v; ex_cmd = c; lit = l; pa = p; pcl_wdata = w; halt = h;
      @(posedge clk);
      #1;
      if (stab && q < 3) chk({tag, " stable"}, pc, pc0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    icycle(0, 3'd0, 9'd0, 2'd0, 8'd0, 0, 0, "rst");
    icycle(0, 3'd0, 9'd0, 2'd0, 8'd0, 0, 0, "rst");
    rst_n = 1'b1;
  endtask

  // Reference model: stack is a 2-entry queue, front = top of stack
  int m_pc, m_depth;
  bit m_flush, m_ovf, m_unf;
  int m_stk[$];

  task automatic m_reset();
    m_pc = 2047; m_depth = 0; m_flush = 1; m_ovf = 0; m_unf = 0;
    m_stk = {0, 0};
  endtask

  task automatic m_step(input bit v, input int cmd, input int l, input int p, input int w, input bit h);
    int c, page, ret;
    c = v ? cmd : 0;
    if (c > 5) c = 0;
    page = p * 512;
    m_flush = c != 0;
    case (c)
      0: if (!h) m_pc = (m_pc + 1) % 2048;
      1: m_pc = page + l;
      2: begin
        m_stk.push_front((m_pc + 1) % 2048);
        void'(m_stk.pop_back());
        if (m_depth == 2) m_ovf = 1; else m_depth++;
        m_pc = page + (l % 256);
      end
      3: begin
        ret = m_stk[0];
        m_stk[0] = m_stk[1];
        if (m_depth == 0) m_unf = 1; else m_depth--;
        m_pc = ret;
      end
      4: m_pc = page + w;
      default: m_pc = (m_pc + 1) % 2048;
    endcase
  endtask

  initial begin
    tbl.push_back(mk(1, 3'd0, 9'h000, 2'd0, 8'h00, 0, 11'h000, 0, 2'd0, 0, 0));
    tbl.push_back(mk(1, 3'd0, 9'h000, 2'd0, 8'h00, 0, 11'h001, 0, 2'd0, 0, 0));
    tbl.push_back(mk(1, 3'd0, 9'h000, 2'd0, 8'h00, 0, 11'h002, 0, 2'd0, 0, 0));
    tbl.push_back(mk(1, 3'd1, 9'h123, 2'd1, 8'h00, 0, 11'h323, 1, 2'd0, 0, 0));
    tbl.push_back(mk(1, 3'd0, 9'h000, 2'd1, 8'h00, 0, 11'h324, 0, 2'd0, 0, 0));
    tbl.push_back(mk(1, 3'd1, 9'h010, 2'd0, 8'h00, 0, 11'h010, 1, 2'd0, 0, 0));
    tbl.push_back(mk(1, 3'd2, 9'h1AB, 2'd0, 8'h00, 0, 11'h0AB, 1, 2'd1, 0, 0));
    tbl.push_back(mk(1, 3'd3, 9'h000, 2'd0, 8'h00, 0, 11'h011, 1, 2'd0, 0, 0));
    tbl.push_back(mk(1, 3'd1, 9'h010, 2'd0, 8'h00, 0, 11'h010, 1, 2'd0, 0, 0));
    tbl.push_back(mk(1, 3'd2, 9'h020, 2'd0, 8'h00, 0, 11'h020, 1, 2'd1, 0, 0));
    tbl.push_back(mk(1, 3'd2, 9'h030, 2'd0, 8'h00, 0, 11'h030, 1, 2'd2, 0, 0));
    tbl.push_back(mk(1, 3'd2, 9'h0FF, 2'd0, 8'h00, 0, 11'h0FF, 1, 2'd2, 1, 0));
    tbl.push_back(mk(1, 3'd3, 9'h000, 2'd0, 8'h00, 0, 11'h031, 1, 2'd1, 1, 0));
    tbl.push_back(mk(1, 3'd3, 9'h000, 2'd0, 8'h00, 0, 11'h021, 1, 2'd0, 1, 0));
    tbl.push_back(mk(1, 3'd3, 9'h000, 2'd0, 8'h00, 0, 11'h021, 1, 2'd0, 1, 1));
    tbl.push_back(mk(1, 3'd1, 9'h050, 2'd0, 8'h00, 0, 11'h050, 1, 2'd0, 1, 1));
    tbl.push_back(mk(1, 3'd5, 9'h000, 2'd0, 8'h00, 0, 11'h051, 1, 2'd0, 1, 1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 3'd0, 9'h000, 2'd0, 8'h00, 1, 11'h051, 0, 2'd0, 1, 1));
    tbl.push_back(mk(1, 3'd1, 9'h077, 2'd0, 8'h00, 1, 11'h077, 1, 2'd0, 1, 1));
    tbl.push_back(mk(0, 3'd1, 9'h155, 2'd2, 8'h00, 0, 11'h078, 0, 2'd0, 1, 1));
    tbl.push_back(mk(1, 3'd7, 9'h155, 2'd2, 8'h00, 0, 11'h079, 0, 2'd0, 1, 1));
    tbl.push_back(mk(1, 3'd6, 9'h155, 2'd2, 8'h00, 1, 11'h079, 0, 2'd0, 1, 1));
    tbl.push_back(mk(1, 3'd1, 9'h1FF, 2'd3, 8'h00, 0, 11'h7FF, 1, 2'd0, 1, 1));
    tbl.push_back(mk(1, 3'd0, 9'h000, 2'd3, 8'h00, 0, 11'h000, 0, 2'd0, 1, 1));
    tbl.push_back(mk(1, 3'd4, 9'h000, 2'd3, 8'hF0, 0, 11'h6F0, 1, 2'd0, 1, 1));

    do_reset();
    chk("reset pc", pc, 11'h7FF);
    chk("reset flush", flush, 1);
    chk("reset depth", stk_depth, 0);
    chk("reset ovf", stk_ovf, 0);
    chk("reset unf", stk_unf, 0);

    foreach (tbl[i]) begin
      icycle(tbl[i].v, tbl[i].c, tbl[i].l, tbl[i].p, tbl[i].w, tbl[i].h, 1, $sformatf("row%0d", i));
      chk($sformatf("row%0d pc", i), pc, tbl[i].e_pc);
      chk($sformatf("row%0d flush", i), flush, tbl[i].e_fl);
      chk($sformatf("row%0d depth", i), stk_depth, tbl[i].e_d);
      chk($sformatf("row%0d ovf", i), stk_ovf, tbl[i].e_o);
      chk($sformatf("row%0d unf", i), stk_unf, tbl[i].e_u);
    end

    // Mid-cycle reset during Q2, then the cycle completes normally
    @(negedge clk); q_phase = 2'd0; ex_valid = 1'b0; halt = 1'b0;
    @(posedge clk); #1;
    chk("midrst Q1 pc", pc, 11'h6F0);
    @(negedge clk); q_phase = 2'd1; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst pc", pc, 11'h7FF);
    chk("midrst flush", flush, 1);
    chk("midrst ovf", stk_ovf, 0);
    chk("midrst unf", stk_unf, 0);
    chk("midrst depth", stk_depth, 0);
    @(negedge clk); q_phase = 2'd2; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst Q3 pc", pc, 11'h7FF);
    @(negedge clk); q_phase = 2'd3;
    @(posedge clk); #1;
    chk("midrst Q4 pc", pc, 11'h000);
    chk("midrst Q4 flush", flush, 0);

    do_reset();
    m_reset();
    for (int n = 0; n < 400; n++) begin
      bit v, h;
      int c, l, p, w;
      v = $urandom_range(0, 9) != 0;
      c = $urandom_range(0, 7);
      l = $urandom_range(0, 511);
      p = $urandom_range(0, 3);
      w = $urandom_range(0, 255);
      h = $urandom_range(0, 3) == 0;
      icycle(v, 3'(c), 9'(l), 2'(p), 8'(w), h, 0, "rnd");
      m_step(v, c, l, p, w, h);
      chk($sformatf("rnd%0d pc", n), pc, m_pc);
      chk($sformatf("rnd%0d flush", n), flush, m_flush);
      chk($sformatf("rnd%0d depth", n), stk_depth, m_depth);
      chk($sformatf("rnd%0d ovf", n), stk_ovf, m_ovf);
      chk($sformatf("rnd%0d unf", n), stk_unf, m_unf);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
